// File: rtl/float_copro_dispatch_if.sv
// Bundle of request, response and coprocessor handshake signals around the dispatcher.
// master = dispatcher side, slave = requester plus coprocessor environment.
interface float_copro_dispatch_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [10:0]      req_opcode;
  logic [31:0]      req_op0;
  logic [31:0]      req_op1;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  logic             copro_valid;
  logic [10:0]      copro_opcode;
  logic [31:0]      copro_op0;
  logic [31:0]      copro_op1;
  logic             copro_complete;
  logic [31:0]      copro_result;
  logic             copro_accept;

  logic             busy;

  modport master (
    input  req_valid, req_opcode, req_op0, req_op1, req_tag,
    input  rsp_ready, copro_complete, copro_result,
    output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err,
    output copro_valid, copro_opcode, copro_op0, copro_op1, copro_accept, busy
  );

  modport slave (
    output req_valid, req_opcode, req_op0, req_op1, req_tag,
    output rsp_ready, copro_complete, copro_result,
    input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err,
    input  copro_valid, copro_opcode, copro_op0, copro_op1, copro_accept, busy
  );
endinterface

// File: rtl/float_copro_dispatch.sv
// Issue stage for the FP coprocessor: request FIFO, one-at-a-time issue FSM,
// illegal-opcode screening and timeout recovery, tagged valid/ready responses.
module float_copro_dispatch #(
  parameter int          DEPTH   = 4,
  parameter int          TAG_W   = 4,
  parameter int          TIMEOUT = 31,
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input logic                   clk,
  input logic                   reset,
  float_copro_dispatch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCEPT, S_RESP} state_t;

  logic [10:0]      r_fifo_opcode [DEPTH];
  logic [31:0]      r_fifo_op0    [DEPTH];
  logic [31:0]      r_fifo_op1    [DEPTH];
  logic [TAG_W-1:0] r_fifo_tag    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_copro_valid;
  logic             r_copro_accept;
  logic [10:0]      r_copro_opcode;
  logic [31:0]      r_copro_op0;
  logic [31:0]      r_copro_op1;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_head_legal;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign bus.req_ready = !w_full || w_pop;
  assign w_push       = bus.req_valid && bus.req_ready;
  assign w_head_legal = (r_fifo_opcode[r_rd_ptr][10:2] == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_opcode[r_wr_ptr] <= bus.req_opcode;
      r_fifo_op0[r_wr_ptr]    <= bus.req_op0;
      r_fifo_op1[r_wr_ptr]    <= bus.req_op1;
      r_fifo_tag[r_wr_ptr]    <= bus.req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_copro_valid  <= 1'b0;
      r_copro_accept <= 1'b0;
      r_copro_opcode <= '0;
      r_copro_op0    <= '0;
      r_copro_op1    <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_tag      <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_copro_valid  <= 1'b0;
      r_copro_accept <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_copro_opcode <= r_fifo_opcode[r_rd_ptr];
            r_copro_op0    <= r_fifo_op0[r_rd_ptr];
            r_copro_op1    <= r_fifo_op1[r_rd_ptr];
            r_rsp_tag      <= r_fifo_tag[r_rd_ptr];
            if (w_head_legal) begin
              r_copro_valid <= 1'b1;
              r_state       <= S_ISSUE;
            end else begin
              r_rsp_result <= NAN_VAL;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.copro_complete) begin
            r_rsp_result   <= bus.copro_result;
            r_rsp_err      <= 1'b0;
            r_copro_accept <= 1'b1;
            r_state        <= S_ACCEPT;
          end else if (r_timer == TMR_W'(TIMEOUT)) begin
            // Hung coprocessor: still pulse accept so it can clear itself.
            r_rsp_result   <= NAN_VAL;
            r_rsp_err      <= 1'b1;
            r_copro_accept <= 1'b1;
            r_state        <= S_ACCEPT;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_ACCEPT: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.copro_valid  = r_copro_valid;
  assign bus.copro_accept = r_copro_accept;
  assign bus.copro_opcode = r_copro_opcode;
  assign bus.copro_op0    = r_copro_op0;
  assign bus.copro_op1    = r_copro_op1;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_tag      = r_rsp_tag;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.busy         = (r_state != S_IDLE) || !w_empty;
endmodule
